// File: rtl/event_gen_pkg.sv
// event_gen_pkg
// Shared types and constants for the event generator unit: channel FSM
// states, channel modes, count/period widths and a helper that sizes the
// channel-select field.
// Optional feature macro: EVENT_GEN_PERIODIC_EN. When it is defined, the
// channels have periodic reload.
package event_gen_pkg;

  localparam int COUNT_W  = 64;
  localparam int PERIOD_W = 32;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } chState_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } chMode_t;

  // Width of a channel index. A single-channel build still gets a 1-bit select.
  function automatic int chIdxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_gen_channel.sv
// event_gen_channel
// One compare channel. It holds the channel FSM (idle/armed), the compare
// value, the optional reload period and mode, the registered event pulse and
// the sticky pending flag.
// Optional feature macro: EVENT_GEN_PERIODIC_EN. When it is defined, period
// and mode storage and the reload adder are present. When it is not defined,
// the channel is always one-shot.
// Ports:
//   ck, arstn        clock, asynchronous active-low reset
//   countLoad        count register loads this cycle (increment or clear)
//   countNext        value the count register takes on this load
//   wrEn             accepted configuration write aimed at this channel
//   wrCompare/wrPeriod/wrMode/wrArm  configuration write data
//   pendingClr       clears the pending flag (set has priority)
//   evt              one-cycle match pulse, aligned with the matching count
//   pending          sticky match flag, set the cycle after evt
module event_gen_channel
  import event_gen_pkg::*;
(
  input  logic                ck,
  input  logic                arstn,
  input  logic                countLoad,
  input  logic [COUNT_W-1:0]  countNext,
  input  logic                wrEn,
  input  logic [COUNT_W-1:0]  wrCompare,
  input  logic [PERIOD_W-1:0] wrPeriod,
  input  logic                wrMode,
  input  logic                wrArm,
  input  logic                pendingClr,
  output logic                evt,
  output logic                pending
);

  chState_t           state;
  logic [COUNT_W-1:0] cmp;
  logic               match;
  logic               reload;
  logic [COUNT_W-1:0] reloadCmp;

  // A match is judged against the value the count register is about to
  // take, so the registered pulse lines up with that count value.
  assign match = countLoad && (state == CH_ARMED) && (countNext == cmp);

`ifdef EVENT_GEN_PERIODIC_EN
  chMode_t             mode;
  logic [PERIOD_W-1:0] period;

  // A zero period degrades to one-shot so that the channel cannot re-fire
  // on every later load at the same value.
  assign reload    = (mode == MODE_PERIODIC) && (period != '0);
  assign reloadCmp = cmp + COUNT_W'(period);
`else
  logic unusedCfg;

  assign unusedCfg = ^{wrMode, wrPeriod};
  assign reload    = 1'b0;
  assign reloadCmp = cmp;
`endif

  // Channel FSM. The event comes from the configuration that was present
  // before this edge. A write on the same edge replaces any periodic reload.
  // Pending captures the previous cycle's pulse and wins over a clear.
  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      state   <= CH_IDLE;
      cmp     <= '0;
      evt     <= 1'b0;
      pending <= 1'b0;
`ifdef EVENT_GEN_PERIODIC_EN
      mode    <= MODE_ONESHOT;
      period  <= '0;
`endif
    end else begin
      evt     <= match;
      pending <= evt | (pending & ~pendingClr);
      if (wrEn) begin
        cmp   <= wrCompare;
        state <= wrArm ? CH_ARMED : CH_IDLE;
`ifdef EVENT_GEN_PERIODIC_EN
        mode   <= chMode_t'(wrMode);
        period <= wrPeriod;
`endif
      end else if (match) begin
        if (reload) begin
          cmp <= reloadCmp;
        end else begin
          state <= CH_IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/event_generator_unit.sv
// event_generator_unit
// Timebase and compare-event generator. A prescaler advances a 64-bit
// free-running count. NUM_CH compare channels raise one-cycle event pulses
// and sticky pending flags when the count reaches their compare value.
// Channels are configured through a valid/ready write port.
// Optional feature macro: EVENT_GEN_PERIODIC_EN. It enables periodic reload
// in the channels. The port list is the same with or without it.
// Parameters: NUM_CH (1..16), PRESCALE (ck cycles per count increment).
// Ports:
//   ck, arstn      clock, asynchronous active-low reset
//   enable, clear  prescaler run enable, synchronous count/prescaler clear
//   wrValid/wrReady/wrCh/wrCompare/wrPeriod/wrMode/wrArm  config write port
//   count, tick    current count, high in the cycle count was incremented
//   events         per-channel match pulses ("event" is a reserved word)
//   pending        per-channel sticky match flags, cleared by pendingClr
module event_generator_unit
  import event_gen_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int PRESCALE = 16,
  localparam int CH_W     = chIdxWidth(NUM_CH)
) (
  input  logic                ck,
  input  logic                arstn,
  input  logic                enable,
  input  logic                clear,
  input  logic                wrValid,
  output logic                wrReady,
  input  logic [CH_W-1:0]     wrCh,
  input  logic [COUNT_W-1:0]  wrCompare,
  input  logic [PERIOD_W-1:0] wrPeriod,
  input  logic                wrMode,
  input  logic                wrArm,
  output logic [COUNT_W-1:0]  count,
  output logic                tick,
  output logic [NUM_CH-1:0]   events,
  output logic [NUM_CH-1:0]   pending,
  input  logic [NUM_CH-1:0]   pendingClr
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]   presc;
  logic [COUNT_W-1:0] countReg;
  logic [COUNT_W-1:0] countNext;
  logic               incDue;
  logic               countLoad;
  logic               wrAccept;

  // Both an increment and a clear count as a load, and the channels compare
  // against whatever value the count is about to take.
  assign incDue    = enable && (presc == PRE_W'(PRESCALE - 1));
  assign countLoad = clear || incDue;
  assign countNext = clear ? '0 : countReg + COUNT_W'(1);
  assign wrAccept  = wrValid && wrReady;
  assign count     = countReg;

  // Prescaler and count. Clear wins over an increment that is due on the
  // same edge and never produces a tick.
  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      presc    <= '0;
      countReg <= '0;
      tick     <= 1'b0;
    end else if (clear) begin
      presc    <= '0;
      countReg <= '0;
      tick     <= 1'b0;
    end else if (incDue) begin
      presc    <= '0;
      countReg <= countNext;
      tick     <= 1'b1;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

  // Write handshake. Ready stays low through reset and comes up on the first
  // edge after it. It then drops for one cycle after every accept, which
  // caps throughput at one write every two cycles.
  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      wrReady <= 1'b0;
    end else begin
      wrReady <= !wrAccept;
    end
  end

  // Per-channel compare logic. A write whose channel index is out of range
  // matches no channel and is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : gChannel
    event_gen_channel uChannel (
      .ck         (ck),
      .arstn      (arstn),
      .countLoad  (countLoad),
      .countNext  (countNext),
      .wrEn       (wrAccept && (wrCh == CH_W'(i))),
      .wrCompare  (wrCompare),
      .wrPeriod   (wrPeriod),
      .wrMode     (wrMode),
      .wrArm      (wrArm),
      .pendingClr (pendingClr[i]),
      .evt        (events[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_event_generator_unit.sv
// tb_event_generator_unit
// Self-checking bench for event_generator_unit (NUM_CH=4, PRESCALE=16).
// It has a table of channel configurations with their expected event counts,
// hand-written sequences for timing and corner cases, and a randomized run
// checked against a cycle-level behavioural model.
// Optional feature macro: EVENT_GEN_PERIODIC_EN. It selects the periodic
// expectations.
module tb_event_generator_unit;

  localparam int NCH = 4;
  localparam int P   = 16;
`ifdef EVENT_GEN_PERIODIC_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif

  logic        ck = 1'b0;
  logic        arstn;
  logic        enable, clear, wrValid, wrReady, wrMode, wrArm, tick;
  logic [1:0]  wrCh;
  logic [63:0] wrCompare, count;
  logic [31:0] wrPeriod;
  logic [3:0]  events, pending, pendingClr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          ch;
    logic [63:0] cmp;
    logic [31:0] period;
    logic        mode;
    logic        arm;
    logic [31:0] expMask;
  } vec_t;

  vec_t vecs[6];

  // Behavioural model state
  logic [63:0] mCount;
  int          mEnCycles;
  logic        mTick, mReady;
  logic [3:0]  mEvt, mPending;
  logic [63:0] mCmp[4];
  logic [31:0] mPeriod[4];
  logic        mPeriodic[4], mArmed[4];

  event_generator_unit #(.NUM_CH(NCH), .PRESCALE(P)) dut (
    .ck(ck), .arstn(arstn), .enable(enable), .clear(clear),
    .wrValid(wrValid), .wrReady(wrReady), .wrCh(wrCh), .wrCompare(wrCompare),
    .wrPeriod(wrPeriod), .wrMode(wrMode), .wrArm(wrArm), .count(count),
    .tick(tick), .events(events), .pending(pending), .pendingClr(pendingClr)
  );

  always #5 ck = ~ck;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    enable = 0; clear = 0; wrValid = 0; wrCh = 0; wrCompare = 0;
    wrPeriod = 0; wrMode = 0; wrArm = 0; pendingClr = 0;
  endtask

  task automatic cycle();
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic doReset();
    idleInputs();
    @(negedge ck);
    arstn = 0;
    @(negedge ck);
    @(negedge ck);
    arstn = 1;
  endtask

  task automatic writeCfg(input logic [1:0] ch, input logic [63:0] cmpV, input logic [31:0] per,
                          input logic md, input logic arm);
    int n = 0;
    while (!wrReady && n < 8) begin
      cycle();
      n++;
    end
    checkOutput("wr_ready_wait", wrReady, 1);
    wrValid = 1; wrCh = ch; wrCompare = cmpV; wrPeriod = per; wrMode = md; wrArm = arm;
    cycle();
    wrValid = 0;
  endtask

  task automatic waitEvt(input int ch, input int maxCycles, input string name);
    bit seen = 0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      cycle();
      if (events[ch]) seen = 1;
    end
    checkOutput(name, seen, 1);
  endtask

  task automatic modelReset();
    mCount = 0; mEnCycles = 0; mTick = 0; mReady = 0; mEvt = 0; mPending = 0;
    for (int c = 0; c < NCH; c++) begin
      mCmp[c] = 0; mPeriod[c] = 0; mPeriodic[c] = 0; mArmed[c] = 0;
    end
  endtask

  // Advances the model by one clock using the current inputs, then clocks the DUT.
  task automatic applyStimulus();
    logic        acc, ld;
    logic [63:0] nc;
    logic [3:0]  ne;
    acc      = wrValid && mReady;
    mPending = mEvt | (mPending & ~pendingClr);
    ld = 0; nc = mCount; mTick = 0;
    if (clear) begin
      ld = 1; nc = 0; mEnCycles = 0;
    end else if (enable) begin
      mEnCycles++;
      if (mEnCycles == P) begin
        mEnCycles = 0; ld = 1; nc = mCount + 64'd1; mTick = 1;
      end
    end
    ne = 0;
    for (int c = 0; c < NCH; c++) begin
      if (ld && mArmed[c] && nc == mCmp[c]) begin
        ne[c] = 1;
        if (PER && mPeriodic[c] && mPeriod[c] != 0) mCmp[c] = mCmp[c] + 64'(mPeriod[c]);
        else mArmed[c] = 0;
      end
    end
    if (acc) begin
      mCmp[wrCh] = wrCompare; mPeriod[wrCh] = wrPeriod;
      mPeriodic[wrCh] = wrMode; mArmed[wrCh] = wrArm;
    end
    mReady = !acc; mCount = nc; mEvt = ne;
    cycle();
  endtask

  task automatic testReset();
    idleInputs();
    arstn = 0;
    @(negedge ck);
    @(negedge ck);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_events", events, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_ready", wrReady, 0);
    arstn = 1;
    #1 checkOutput("rst_ready_release", wrReady, 0);
    cycle();
    checkOutput("rst_ready_up", wrReady, 1);
  endtask

  task automatic testTiming();
    doReset();
    enable = 1;
    for (int k = 1; k <= 160; k++) begin
      cycle();
      if (k == 15) begin checkOutput("tm_count15", count, 0); checkOutput("tm_tick15", tick, 0); end
      if (k == 16) begin checkOutput("tm_count16", count, 1); checkOutput("tm_tick16", tick, 1); end
      if (k == 17) checkOutput("tm_tick17", tick, 0);
      if (k == 160) begin checkOutput("tm_count160", count, 10); checkOutput("tm_tick160", tick, 1); end
    end
    enable = 0;
  endtask

  task automatic testTable();
    logic [31:0] mask;
    logic [3:0]  other;
    vecs[0] = '{ch:0, cmp:64'd5, period:32'd0, mode:1'b0, arm:1'b1, expMask:32'h20};
    vecs[1] = '{ch:1, cmp:64'd3, period:32'd4, mode:1'b1, arm:1'b1, expMask:(PER ? 32'h88888 : 32'h8)};
    vecs[2] = '{ch:2, cmp:64'd6, period:32'd0, mode:1'b1, arm:1'b1, expMask:32'h40};
    vecs[3] = '{ch:3, cmp:64'd0, period:32'd0, mode:1'b0, arm:1'b1, expMask:32'h0};
    vecs[4] = '{ch:1, cmp:64'd2, period:32'd9, mode:1'b1, arm:1'b1, expMask:(PER ? 32'h100804 : 32'h4)};
    vecs[5] = '{ch:0, cmp:64'd4, period:32'd0, mode:1'b0, arm:1'b0, expMask:32'h0};
    for (int v = 0; v < 6; v++) begin
      doReset();
      cycle();
      writeCfg(2'(vecs[v].ch), vecs[v].cmp, vecs[v].period, vecs[v].mode, vecs[v].arm);
      mask = 0; other = 0;
      enable = 1;
      for (int c = 0; c < 325; c++) begin
        cycle();
        if (events[vecs[v].ch] && count < 32) mask[count[4:0]] = 1'b1;
        other = other | (events & ~(4'b0001 << vecs[v].ch));
      end
      enable = 0;
      checkOutput($sformatf("table%0d_mask", v), mask, vecs[v].expMask);
      checkOutput($sformatf("table%0d_other", v), other, 0);
    end
  endtask

  task automatic testOneShotWrap();
    int ev0 = 0;
    doReset();
    cycle();
    writeCfg(0, 64'd5, 0, 0, 1);
    enable = 1;
    waitEvt(0, 200, "os_evt_seen");
    checkOutput("os_evt_count", count, 5);
    cycle();
    checkOutput("os_evt_single", events[0], 0);
    checkOutput("os_pending_set", pending[0], 1);
    repeat (40) cycle();
    checkOutput("os_pending_sticky", pending[0], 1);
    pendingClr = 4'b0001;
    cycle();
    pendingClr = 0;
    checkOutput("os_pending_clr", pending[0], 0);
    writeCfg(3, 64'd0, 0, 0, 1);
    dut.countReg = 64'hFFFF_FFFF_FFFF_FFFE;
    waitEvt(3, 100, "wrap_evt_seen");
    checkOutput("wrap_evt_count", count, 0);
    for (int i = 0; i < 7 * P; i++) begin
      cycle();
      if (events[0]) ev0++;
    end
    checkOutput("wrap_count_after", count, 7);
    checkOutput("wrap_oneshot_quiet", ev0, 0);
    enable = 0;
  endtask

  task automatic testClear();
    doReset();
    enable = 1;
    repeat (P * 3 + 15) cycle();
    checkOutput("clr_pre_count", count, 3);
    clear = 1;
    cycle();
    clear = 0;
    checkOutput("clr_count", count, 0);
    checkOutput("clr_tick", tick, 0);
    repeat (P - 1) cycle();
    checkOutput("clr_next_hold", count, 0);
    cycle();
    checkOutput("clr_next_count", count, 1);
    checkOutput("clr_next_tick", tick, 1);
    enable = 0;
  endtask

  task automatic testBackToBack();
    logic [7:0] m0, m2;
    doReset();
    cycle();
    checkOutput("b2b_ready_init", wrReady, 1);
    wrValid = 1; wrCh = 0; wrCompare = 64'd1; wrPeriod = 0; wrMode = 0; wrArm = 1;
    cycle();
    checkOutput("b2b_ready_low", wrReady, 0);
    wrCh = 2; wrCompare = 64'd2;
    cycle();
    checkOutput("b2b_ready_back", wrReady, 1);
    cycle();
    checkOutput("b2b_second_accept", wrReady, 0);
    wrValid = 0;
    m0 = 0; m2 = 0;
    enable = 1;
    for (int i = 0; i < 3 * P + 4; i++) begin
      cycle();
      if (events[0] && count < 8) m0[count[2:0]] = 1'b1;
      if (events[2] && count < 8) m2[count[2:0]] = 1'b1;
    end
    enable = 0;
    checkOutput("b2b_ch0_events", m0, 8'b0000_0010);
    checkOutput("b2b_ch2_events", m2, 8'b0000_0100);
  endtask

  task automatic testPendingClr();
    doReset();
    cycle();
    writeCfg(0, 64'd2, 0, 0, 1);
    enable = 1;
    waitEvt(0, 100, "pclr_evt_seen");
    pendingClr = 4'b0001;
    cycle();
    checkOutput("pclr_set_wins", pending[0], 1);
    cycle();
    checkOutput("pclr_clears", pending[0], 0);
    pendingClr = 0;
    enable = 0;
  endtask

  task automatic testRandom();
    doReset();
    modelReset();
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 299) == 0);
      wrValid    = ($urandom_range(0, 4) == 0);
      wrCh       = 2'($urandom_range(0, 3));
      wrCompare  = mCount + 64'($urandom_range(0, 10));
      wrPeriod   = 32'($urandom_range(0, 4));
      wrMode     = 1'($urandom_range(0, 1));
      wrArm      = ($urandom_range(0, 4) != 0);
      pendingClr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus();
      checkOutput("rnd_count", count, mCount);
      checkOutput("rnd_tick", tick, mTick);
      checkOutput("rnd_events", events, mEvt);
      checkOutput("rnd_pending", pending, mPending);
      checkOutput("rnd_ready", wrReady, mReady);
    end
    idleInputs();
  endtask

  task automatic testAsyncReset();
    doReset();
    cycle();
    writeCfg(1, 64'd3, 0, 0, 1);
    enable = 1;
    waitEvt(1, 100, "arst_evt_seen");
    cycle();
    checkOutput("arst_pre_pending", pending[1], 1);
    #2 arstn = 0;
    #1;
    checkOutput("arst_count", count, 0);
    checkOutput("arst_tick", tick, 0);
    checkOutput("arst_events", events, 0);
    checkOutput("arst_pending", pending, 0);
    checkOutput("arst_ready", wrReady, 0);
    idleInputs();
    @(negedge ck);
    arstn = 1;
  endtask

  initial begin
    testReset();
    testTiming();
    testTable();
    testOneShotWrap();
    testClear();
    testBackToBack();
    testPendingClr();
    testRandom();
    testAsyncReset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_generator_unit.md
# event_generator_unit

Timebase and compare-event generator feeding the event-generator assertion checker. Holds a 64-bit free-running count advanced by a prescaler, plus NUM_CH compare channels that emit single-cycle event pulses and sticky pending flags. Channels are configured through a valid/ready write port. `count`, `tick`, `event` and `pending` are the signals the downstream checker observes.

## Interface
Parameters:
- NUM_CH, 4: number of compare channels (1..16).
- PRESCALE, 16: `ck` cycles per count increment (1 = every cycle; 16 gives 1 MHz from 16 MHz).

Ports:
- ck  in  1  system clock (16 MHz domain).
- arstn  in  1  reset; asynchronous assert, active-low.
- enable  in  1  prescaler/count run enable.
- clear  in  1  synchronous count and prescaler clear.
- wrValid  in  1  configuration write request.
- wrReady  out  1  write port can accept.
- wrCh  in  $clog2(NUM_CH) (min 1)  target channel.
- wrCompare  in  64  absolute compare value.
- wrPeriod  in  32  reload period (periodic mode).
- wrMode  in  1  0 one-shot, 1 periodic.
- wrArm  in  1  1 arm channel, 0 disarm.
- count  out  64  current count.
- tick  out  1  high in the cycle `count` was incremented.
- event  out  NUM_CH  one-cycle match pulses.
- pending  out  NUM_CH  sticky match flags.
- pendingClr  in  NUM_CH  per-channel pending clear.

## Operation
- Prescaler: counts 0..PRESCALE-1 while `enable`=1; holds when `enable`=0. When it would pass PRESCALE-1, it wraps to 0, `count` increments and `tick` is registered high for one cycle.
- Count: wraps from 2^64-1 to 0. `clear` loads count=0 and prescaler=0, regardless of `enable`, and takes priority over an increment in the same cycle. `tick` is 0 on clear.
- A count load is either an increment or a clear. On every count load, each ARMED channel compares the new count value with its `cmp`.
- Channel FSM, states CH_IDLE and CH_ARMED:
  - Match in CH_ARMED: `event[i]`=1 in the same cycle `count` shows the matching value.
  - One-shot: go to CH_IDLE.
  - Periodic, period≠0: cmp←cmp+period (mod 2^64); stay CH_ARMED.
  - Periodic, period=0: behaves as one-shot.
- Compare already passed: no event until count wraps around to that value.
- Write port:
  - Write accepted when wrValid&&wrReady.
  - `wrReady` drops for exactly one cycle after each accept. Sustained throughput is one write per 2 cycles.
  - On accept: cmp←wrCompare, period←wrPeriod, mode←wrMode; state←CH_ARMED if wrArm else CH_IDLE.
  - The new configuration is used from the next count load.
- Write and match on the same channel in the same cycle: the event from the old configuration still pulses and sets pending. The written values replace the periodic reload.
- Pending: set by `event[i]`, cleared by `pendingClr[i]`. Set wins when both occur in the same cycle.
- Reset values: count=0, prescaler=0, tick=0, event=0, pending=0, all channels CH_IDLE with cmp=0 and period=0, wrReady=0. `wrReady` becomes 1 on the first cycle after `arstn` deasserts.
- Reset mid-operation clears everything immediately (asynchronous). A write in flight is lost.

## Timing
- Increment latency: with `enable` held high, the first tick is PRESCALE cycles after enable rises. Later ticks follow every PRESCALE cycles.
- `event` and `tick` are registered and aligned with the `count` value that caused them. Combinational path from inputs to outputs: none.
- Pending is visible the cycle after `event`.
- Configuration takes effect 1 cycle after accept.

## Configuration
- EVENT_GEN_PERIODIC_EN defined: periodic mode, `period` registers and the reload adder are present.
- Not defined: `wrMode` and `wrPeriod` are ignored and every channel is one-shot. No period storage or adder is instantiated. Port list is unchanged.

## Structure
- Package event_gen_pkg:
  - chState_t {CH_IDLE, CH_ARMED}.
  - chMode_t {MODE_ONESHOT, MODE_PERIODIC}.
  - Constants COUNT_W=64 and PERIOD_W=32.
- Sub-module event_gen_channel holds one channel's FSM, cmp, period and pending logic. It is generated NUM_CH times.
- The top level holds the prescaler, count and write handshake.

## Test plan
- Reset then enable with PRESCALE=16 → first tick in cycle 16, count=1; count=10 after 160 cycles; wrReady=1 one cycle after arstn rises.
- Ch0 one-shot, cmp=5 → single event[0] when count=5; pending[0]=1 until pendingClr[0]; no event at the next wrap.
- Ch1 periodic, cmp=3, period=4 (macro on) → events at counts 3, 7, 11; with macro off → only count 3.
- Back-to-back wrValid for ch0 and ch2 → second accepted 2 cycles after the first; wrReady low in between.
- count preloaded to 2^64-2 (forced), ch3 cmp=0 → count wraps to 0 and event[3] fires; `clear` asserted with an increment due → count=0, tick=0.
- pendingClr[0] in the same cycle as event[0] → pending[0] stays 1; arstn pulsed mid-count → all outputs 0 immediately.
